oam_dma: RTL
============

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter REG_ADDR, default 16'hFF46, SHALL be the CPU-visible DMA source register address.
REQ-002 Parameter DMA_LEN, default 160, SHALL be the number of bytes per transfer.
REQ-003 Parameter START_DELAY, default 1, SHALL be the number of idle cycles between the register write and the first read.
REQ-004 clk  input  1  SHALL be the system clock; all state changes on the rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 cpu_addr  input  16  SHALL be the CPU bus address.
REQ-007 cpu_wdata  input  8  SHALL be the CPU write data.
REQ-008 cpu_write_en  input  1  SHALL be the CPU write strobe.
REQ-009 reg_rdata  output  8  SHALL be the current source-page register value.
REQ-010 dma_active  output  1  SHALL indicate the engine owns the bus; the MMU uses it to block CPU access outside HRAM.
REQ-011 dma_addr  output  16  SHALL be the address driven by the engine.
REQ-012 dma_read_en  output  1  SHALL be the engine read strobe.
REQ-013 dma_write_en  output  1  SHALL be the engine write strobe.
REQ-014 dma_wdata  output  8  SHALL be the engine write data.
REQ-015 dma_rdata  input  8  SHALL be the read data returned combinationally by the MMU in the same cycle.
REQ-016 dma_done  output  1  SHALL be a one-cycle pulse after the last byte is written.

Function
REQ-017 A register write SHALL occur when cpu_write_en=1 and cpu_addr==REG_ADDR at a rising edge; src SHALL load cpu_wdata, idx SHALL clear to 0, and the state SHALL enter START.
REQ-018 The states SHALL be IDLE, START, READ and WRITE.
REQ-019 START SHALL last START_DELAY cycles, counted by a delay counter, and SHALL then go to READ; with START_DELAY=0, the state SHALL go straight to READ.
REQ-020 In READ, outputs SHALL be dma_read_en=1, dma_write_en=0 and dma_addr={src,idx}; the engine SHALL latch dma_rdata into a data buffer at the closing edge and go to WRITE.
REQ-021 In WRITE, outputs SHALL be dma_write_en=1, dma_read_en=0, dma_addr={8'hFE,idx} and dma_wdata=buffer.
REQ-022 At the end of WRITE, if idx<DMA_LEN-1, idx SHALL increment and the state SHALL go to READ.
REQ-023 At the end of WRITE, if idx==DMA_LEN-1, the state SHALL go to IDLE and dma_done SHALL assert for the following cycle.
REQ-024 dma_active SHALL be 1 only in READ or WRITE; in IDLE and START, dma_addr SHALL be 0 and all strobes SHALL be 0.
REQ-025 A transfer SHALL last START_DELAY+2*DMA_LEN cycles from the write edge to dma_done (321 cycles at defaults).
REQ-026 idx SHALL be 8 bits and the low address byte SHALL be idx unscaled; src SHALL pass through unmodified, and echo-region mapping is the MMU's job.
REQ-027 A register write during START, READ or WRITE SHALL restart: src updated, idx=0, state START, and no dma_done for the aborted transfer.
REQ-028 A register write coinciding with the final WRITE SHALL restart, and dma_done SHALL NOT pulse.
REQ-029 reg_rdata SHALL always equal src, independent of state.
REQ-030 The engine SHALL ignore cpu_read_en and SHALL have no bus wait or backpressure; each READ and WRITE SHALL take exactly one cycle.

Reset
REQ-031 Asynchronous reset SHALL force state=IDLE, src=8'h00, idx=0, the delay counter to 0 and the data buffer to 0.
REQ-032 During reset, every output SHALL be 0, and reg_rdata SHALL read 8'h00.
REQ-033 A reset mid-transfer SHALL abort immediately with no dma_done; the next transfer SHALL require a new register write.

Structure
REQ-034 dma_state_t (IDLE/START/READ/WRITE), OAM_PAGE=8'hFE and DMA_REG_ADDR=16'hFF46 SHALL live in the shared MMU addresses/types package.
REQ-035 The block SHALL be a single module with no sub-module; the MMU SHALL instantiate it and mux dma_addr and the strobes onto effective_addr.

Verification
REQ-036 Write 8'hC1 to FF46 at defaults -> one idle cycle, then alternating read C100/write FE00 ... read C19F/write FE9F; dma_done at cycle 321; dma_active high for 320 cycles.
REQ-037 Model memory C100+i=i^8'h5A -> FE00+i=i^8'h5A for i=0..159; reg_rdata=8'hC1 throughout.
REQ-038 Write 8'hC1, then write 8'hD0 at idx=50 -> restart at D000, no done for the first transfer, a single dma_done 321 cycles after the second write.
REQ-039 Assert reset at idx=80 during WRITE -> outputs 0 asynchronously, reg_rdata=00, no dma_done; after release the engine stays IDLE.
REQ-040 START_DELAY=0, DMA_LEN=4, write 8'h80 -> reads 8000..8003 and writes FE00..FE03; dma_done 8 cycles after the write edge.
REQ-041 Write FF46 on the cycle of the final WRITE -> the new transfer starts and dma_done does not pulse.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared MMU address/type definitions used by the OAM DMA engine.
//   dma_state_t  : engine sequencing states
//   OAM_PAGE     : high address byte of object attribute memory
//   DMA_REG_ADDR : CPU-visible DMA source-page register address
package oam_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    localparam logic [7:0]  OAM_PAGE     = 8'hFE;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

endpackage

// File: rtl/oam_dma_if.sv
// Bus bundle between the MMU and the OAM DMA engine.
//   master : MMU side; drives the CPU register port and the read data
//   slave  : DMA engine side; exposes the source register and the engine bus
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write_en;
    logic [7:0]  reg_rdata;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_read_en;
    logic        dma_write_en;
    logic [7:0]  dma_wdata;
    logic [7:0]  dma_rdata;
    logic        dma_done;

    modport master (
        output cpu_addr, cpu_wdata, cpu_write_en, dma_rdata,
        input  reg_rdata, dma_active, dma_addr, dma_read_en, dma_write_en,
               dma_wdata, dma_done
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_write_en, dma_rdata,
        output reg_rdata, dma_active, dma_addr, dma_read_en, dma_write_en,
               dma_wdata, dma_done
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the source register copies DMA_LEN bytes
// from page {src,00} into the OAM page, one read cycle then one write cycle
// per byte, after START_DELAY idle cycles.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : register port, engine bus, done pulse (oam_dma_if.slave)
//
// state | meaning
// IDLE  | no transfer; bus released
// START | waiting out the start delay (delay counter counts down to 0)
// READ  | read {src,idx}; the returned byte is captured at the closing edge
// WRITE | write buffered byte to {OAM_PAGE,idx}; advance or finish
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] REG_ADDR    = DMA_REG_ADDR,
    parameter int          DMA_LEN     = 160,
    parameter int          START_DELAY = 1
) (
    input logic       clk,
    input logic       reset,
    oam_dma_if.slave  bus
);

    localparam int              DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [7:0]      LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t       state_q, state_d;
    logic [7:0]       src_q;
    logic [7:0]       idx_q;
    logic [DLY_W-1:0] dly_q;
    logic [7:0]       buf_q;
    logic             done_q;

    logic reg_write;
    logic last_write;

    assign reg_write  = bus.cpu_write_en && (bus.cpu_addr == REG_ADDR);
    assign last_write = (state_q == WRITE) && (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.dma_active   = 1'b0;
        bus.dma_addr     = 16'h0000;
        bus.dma_read_en  = 1'b0;
        bus.dma_write_en = 1'b0;
        bus.dma_wdata    = 8'h00;

        unique case (state_q)
            IDLE: ;
            START: begin
                if (dly_q == '0) state_d = READ;
            end
            READ: begin
                bus.dma_active  = 1'b1;
                bus.dma_read_en = 1'b1;
                bus.dma_addr    = {src_q, idx_q};
                state_d         = WRITE;
            end
            WRITE: begin
                bus.dma_active   = 1'b1;
                bus.dma_write_en = 1'b1;
                bus.dma_addr     = {OAM_PAGE, idx_q};
                bus.dma_wdata    = buf_q;
                state_d          = last_write ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase

        // A register write always wins, including over an in-flight transfer.
        if (reg_write) state_d = (START_DELAY == 0) ? READ : START;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= 8'h00;
            idx_q  <= 8'h00;
            dly_q  <= '0;
            buf_q  <= 8'h00;
            done_q <= 1'b0;
        end else begin
            // A restart landing on the final write cancels the completion pulse.
            done_q <= last_write && !reg_write;
            if (reg_write) begin
                src_q <= bus.cpu_wdata;
                idx_q <= 8'h00;
                dly_q <= DLY_LOAD;
            end else begin
                if (state_q == START && dly_q != '0) dly_q <= dly_q - 1'b1;
                if (state_q == READ) buf_q <= bus.dma_rdata;
                if (state_q == WRITE && !last_write) idx_q <= idx_q + 8'd1;
            end
        end
    end

    assign bus.reg_rdata = src_q;
    assign bus.dma_done  = done_q;

endmodule
